// File: rtl/hrange_pair_pkg.sv
// hrange_pair_pkg: shared types and defaults for the hrange_pair range generator.
package hrange_pair_pkg;

  localparam int HRANGE_PAIR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } hrange_pair_state_t;

endpackage

// File: rtl/hrange_pair_if.sv
// hrange_pair_if: generator handshake between a caller (master) and the range
// generator (slave). The caller starts a sequence and accepts tuples; the
// generator presents (_0, _1) tuples with _valid and signals exhaustion with _done.
interface hrange_pair_if import hrange_pair_pkg::*; #(
  parameter int WIDTH = HRANGE_PAIR_WIDTH
);

  logic                    _start;
  logic signed [WIDTH-1:0] base;
  logic signed [WIDTH-1:0] limit;
  logic signed [WIDTH-1:0] step;
  logic                    _ready;
  logic                    _valid;
  logic                    _done;
  logic signed [WIDTH-1:0] _0;
  logic signed [WIDTH-1:0] _1;

  modport master (
    output _start, base, limit, step, _ready,
    input  _valid, _done, _0, _1
  );

  modport slave (
    input  _start, base, limit, step, _ready,
    output _valid, _done, _0, _1
  );

endinterface

// File: rtl/hrange_pair_cmp.sv
// hrange_pair_cmp: combinational range test. A value is in range when it has
// not yet reached the exclusive limit in the direction of the step. A zero step
// or an overflowed candidate is never in range.
module hrange_pair_cmp import hrange_pair_pkg::*; #(
  parameter int WIDTH = HRANGE_PAIR_WIDTH
) (
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] limit,
  input  logic signed [WIDTH-1:0] step,
  input  logic                    ovf,
  output logic                    in_range
);

  // Signed direction-dependent comparison against the exclusive limit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    in_range = 1'b0;
    if (!ovf) begin
      if (step[WIDTH-1]) begin
        in_range = (x > limit);
      end else if (step != '0) begin
        in_range = (x < limit);
      end
    end
  end

endmodule

// File: rtl/hrange_pair.sv
// hrange_pair: hardware range generator yielding (i, k) tuples where i walks
// range(base, limit, step) and k is the 0-based iteration index. One tuple per
// cycle with _ready held high; all outputs are registered.
// Optional feature: define HRANGE_PAIR_OVF_GUARD_EN to end the sequence when
// i + step leaves the signed WIDTH range instead of wrapping.
module hrange_pair import hrange_pair_pkg::*; #(
  parameter int WIDTH = HRANGE_PAIR_WIDTH
) (
  input logic         _clock,
  input logic         _reset,
  hrange_pair_if.slave bus
);

  hrange_pair_state_t state, state_d;

  logic signed [WIDTH-1:0] base_q, limit_q, step_q;
  logic signed [WIDTH-1:0] i_q, i_d;
  logic signed [WIDTH-1:0] k_q, k_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    capture;

  logic signed [WIDTH-1:0] nxt;
  logic                    ovf;
  logic signed [WIDTH-1:0] cmp_x;
  logic                    cmp_ovf;
  logic                    in_range;

`ifdef HRANGE_PAIR_OVF_GUARD_EN
  logic [WIDTH:0] nxt_wide;

  // Sign-extended add: the top two bits disagree exactly when the sum overflows.
  assign nxt_wide = {i_q[WIDTH-1], i_q} + {step_q[WIDTH-1], step_q};
  assign nxt      = nxt_wide[WIDTH-1:0];
  assign ovf      = nxt_wide[WIDTH] ^ nxt_wide[WIDTH-1];
`else
  // Plain wrapping add; a wrapped value is tested against the limit like any other.
  assign nxt = i_q + step_q;
  assign ovf = 1'b0;
`endif

  // LOAD tests the captured base, EMIT tests the next candidate: one comparator serves both.
  assign cmp_x   = (state == LOAD) ? base_q : nxt;
  assign cmp_ovf = (state == LOAD) ? 1'b0 : ovf;

  hrange_pair_cmp #(.WIDTH(WIDTH)) u_cmp (
    .x        (cmp_x),
    .limit    (limit_q),
    .step     (step_q),
    .ovf      (cmp_ovf),
    .in_range (in_range)
  );

  // Next-state and next-output logic; _start aborts any sequence and wins over a transfer.
  always_comb begin
    state_d = state;
    i_d     = i_q;
    k_d     = k_q;
    valid_d = valid_q;
    done_d  = done_q;
    capture = 1'b0;
    if (bus._start) begin
      capture = 1'b1;
      valid_d = 1'b0;
      done_d  = 1'b0;
      state_d = LOAD;
    end else begin
      case (state)
        IDLE: begin
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
        LOAD: begin
          if (in_range) begin
            i_d     = base_q;
            k_d     = '0;
            valid_d = 1'b1;
            state_d = EMIT;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        EMIT: begin
          // A stalled tuple (valid without ready) keeps every output unchanged.
          if (valid_q && bus._ready) begin
            if (in_range) begin
              i_d = nxt;
              k_d = k_q + WIDTH'(1);
            end else begin
              valid_d = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset forces an idle, exhausted generator at once.
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state   <= IDLE;
      i_q     <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b1;
      base_q  <= '0;
      limit_q <= '0;
      step_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state   <= state_d;
      i_q     <= i_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      if (capture) begin
        base_q  <= bus.base;
        limit_q <= bus.limit;
        step_q  <= bus.step;
      end
    end
  end

  assign bus._valid = valid_q;
  assign bus._done  = done_q;
  assign bus._0     = i_q;
  assign bus._1     = k_q;

endmodule

// File: tb/tb_hrange_pair.sv
// tb_hrange_pair: self-checking bench for hrange_pair. Expected tuple streams
// come from a plain-arithmetic model of range(base, limit, step); the bench
// follows the HRANGE_PAIR_OVF_GUARD_EN macro to pick the overflow rule.
module tb_hrange_pair;

  localparam int  W     = 32;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;
`ifdef HRANGE_PAIR_OVF_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk;
  logic rst_n;

  hrange_pair_if #(.WIDTH(W)) bus ();

  hrange_pair #(.WIDTH(W)) dut (
    ._clock (clk),
    ._reset (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Observation state filled by collect().
  logic [63:0] obs[$];
  logic [63:0] exp_q[$];
  int overlap, stall_err, done_edge, last_xfer, first_valid;
  bit timed_out;

  function automatic bit in_rng(longint x, longint l, longint s);
    if (s > 0) return x < l;
    if (s < 0) return x > l;
    return 1'b0;
  endfunction

  // Reference model: enumerate range(b, l, s) with 64-bit arithmetic, then
  // either stop on leaving the 32-bit signed range or wrap into it.
  function automatic void build_exp(longint b, longint l, longint s, int cap);
    longint i;
    longint k;
    logic signed [31:0] t;
    exp_q.delete();
    i = b;
    k = 0;
    while (in_rng(i, l, s) && exp_q.size() < cap) begin
      exp_q.push_back({32'(i), 32'(k)});
      k++;
      i = i + s;
      if (i > MAXV || i < MINV) begin
        if (GUARD) break;
        t = i[31:0];
        i = longint'(t);
      end
    end
  endfunction

  task automatic start_gen(input int b, input int l, input int s);
    bus._start = 1'b1;
    bus.base   = b;
    bus.limit  = l;
    bus.step   = s;
  endtask

  // Runs the handshake after start_gen: mode 0 ready always, 1 pattern 1,0,0,
  // 2 random. Returns on _done, after 'stop' transfers (stop>0), or on budget.
  task automatic collect(input int mode, input int budget, input int stop);
    int e;
    bit rdy, held;
    logic [63:0] held_val;
    e = 0; held = 0; held_val = '0;
    obs.delete();
    overlap = 0; stall_err = 0; done_edge = -1; last_xfer = -1; first_valid = -1;
    timed_out = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); e++;
      @(negedge clk);
      bus._start = 1'b0;
      if (bus._valid && bus._done) overlap++;
      if (held && (!bus._valid || {bus._0, bus._1} !== held_val)) stall_err++;
      if (bus._valid && first_valid < 0) first_valid = e;
      if (bus._done) begin
        done_edge = e;
        return;
      end
      if (stop > 0 && obs.size() >= stop) return;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
      bus._ready = rdy;
      held = bus._valid && !rdy;
      held_val = {bus._0, bus._1};
      if (bus._valid && rdy) begin
        obs.push_back({bus._0, bus._1});
        last_xfer = e + 1;
      end
    end
    timed_out = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (bus._valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus._valid); else n_pass++;
    n_total++; if (bus._done !== 1'b1) $display("FAIL reset_done got %b want 1", bus._done); else n_pass++;
    n_total++; if (bus._0 !== 32'sd0) $display("FAIL reset_0 got %0d want 0", bus._0); else n_pass++;
    n_total++; if (bus._1 !== 32'sd0) $display("FAIL reset_1 got %0d want 0", bus._1); else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (bus._done !== 1'b1 || bus._valid !== 1'b0) $display("FAIL idle_after_reset done=%b valid=%b want 1/0", bus._done, bus._valid); else n_pass++;
  endtask

  task automatic test_basic();
    build_exp(0, 10, 2, 1000);
    start_gen(0, 10, 2);
    collect(0, 100, 0);
    n_total++; if (timed_out) $display("FAIL basic_timeout got timeout want done"); else n_pass++;
    n_total++; if (obs.size() != exp_q.size()) $display("FAIL basic_count got %0d want %0d", obs.size(), exp_q.size()); else n_pass++;
    for (int j = 0; j < obs.size() && j < exp_q.size(); j++) begin
      n_total++;
      if (obs[j] !== exp_q[j]) $display("FAIL basic_tuple%0d got (%0d,%0d) want (%0d,%0d)", j,
        $signed(obs[j][63:32]), $signed(obs[j][31:0]), $signed(exp_q[j][63:32]), $signed(exp_q[j][31:0]));
      else n_pass++;
    end
    n_total++; if (first_valid != 2) $display("FAIL basic_latency got %0d want 2", first_valid); else n_pass++;
    n_total++; if (done_edge != 2 + exp_q.size()) $display("FAIL basic_throughput done_edge got %0d want %0d", done_edge, 2 + exp_q.size()); else n_pass++;
    n_total++; if (done_edge != last_xfer) $display("FAIL basic_done_timing got %0d want %0d", done_edge, last_xfer); else n_pass++;
    n_total++; if (overlap != 0) $display("FAIL basic_overlap got %0d want 0", overlap); else n_pass++;
  endtask

  task automatic test_stall();
    build_exp(10, 0, -3, 1000);
    start_gen(10, 0, -3);
    collect(1, 200, 0);
    n_total++; if (timed_out) $display("FAIL stall_timeout got timeout want done"); else n_pass++;
    n_total++; if (obs.size() != exp_q.size()) $display("FAIL stall_count got %0d want %0d", obs.size(), exp_q.size()); else n_pass++;
    for (int j = 0; j < obs.size() && j < exp_q.size(); j++) begin
      n_total++;
      if (obs[j] !== exp_q[j]) $display("FAIL stall_tuple%0d got (%0d,%0d) want (%0d,%0d)", j,
        $signed(obs[j][63:32]), $signed(obs[j][31:0]), $signed(exp_q[j][63:32]), $signed(exp_q[j][31:0]));
      else n_pass++;
    end
    n_total++; if (stall_err != 0) $display("FAIL stall_hold got %0d changes want 0", stall_err); else n_pass++;
    n_total++; if (overlap != 0) $display("FAIL stall_overlap got %0d want 0", overlap); else n_pass++;
    n_total++; if (done_edge != last_xfer) $display("FAIL stall_done_timing got %0d want %0d", done_edge, last_xfer); else n_pass++;
  endtask

  task automatic test_empty();
    int cases[3][3] = '{'{5, 5, 1}, '{5, 0, 1}, '{0, 10, 0}};
    for (int t = 0; t < 3; t++) begin
      start_gen(cases[t][0], cases[t][1], cases[t][2]);
      collect(0, 20, 0);
      n_total++; if (done_edge != 2) $display("FAIL empty%0d_done_edge got %0d want 2", t, done_edge); else n_pass++;
      n_total++; if (first_valid != -1 || obs.size() != 0) $display("FAIL empty%0d_valid got first_valid %0d want none", t, first_valid); else n_pass++;
    end
  endtask

  task automatic test_overflow();
    build_exp(2147483646, 2147483647, 5, GUARD ? 1000 : 2);
    start_gen(2147483646, 2147483647, 5);
    collect(0, 20, GUARD ? 0 : 2);
    n_total++; if (timed_out) $display("FAIL ovf_timeout got timeout want end"); else n_pass++;
    n_total++; if (obs.size() != exp_q.size()) $display("FAIL ovf_count got %0d want %0d", obs.size(), exp_q.size()); else n_pass++;
    for (int j = 0; j < obs.size() && j < exp_q.size(); j++) begin
      n_total++;
      if (obs[j] !== exp_q[j]) $display("FAIL ovf_tuple%0d got (%0d,%0d) want (%0d,%0d)", j,
        $signed(obs[j][63:32]), $signed(obs[j][31:0]), $signed(exp_q[j][63:32]), $signed(exp_q[j][31:0]));
      else n_pass++;
    end
`ifdef HRANGE_PAIR_OVF_GUARD_EN
    n_total++; if (done_edge != 3) $display("FAIL ovf_done_edge got %0d want 3", done_edge); else n_pass++;
`endif
  endtask

  task automatic test_restart();
    build_exp(0, 100, 1, 3);
    start_gen(0, 100, 1);
    collect(0, 50, 3);
    n_total++; if (obs.size() != 3) $display("FAIL restart_first_count got %0d want 3", obs.size()); else n_pass++;
    for (int j = 0; j < obs.size() && j < exp_q.size(); j++) begin
      n_total++;
      if (obs[j] !== exp_q[j]) $display("FAIL restart_first%0d got (%0d,%0d) want (%0d,%0d)", j,
        $signed(obs[j][63:32]), $signed(obs[j][31:0]), $signed(exp_q[j][63:32]), $signed(exp_q[j][31:0]));
      else n_pass++;
    end
    // _ready is still high here, so the new _start coincides with a transfer.
    build_exp(50, 52, 1, 1000);
    start_gen(50, 52, 1);
    collect(0, 50, 0);
    n_total++; if (obs.size() != exp_q.size()) $display("FAIL restart_count got %0d want %0d", obs.size(), exp_q.size()); else n_pass++;
    for (int j = 0; j < obs.size() && j < exp_q.size(); j++) begin
      n_total++;
      if (obs[j] !== exp_q[j]) $display("FAIL restart_tuple%0d got (%0d,%0d) want (%0d,%0d)", j,
        $signed(obs[j][63:32]), $signed(obs[j][31:0]), $signed(exp_q[j][63:32]), $signed(exp_q[j][31:0]));
      else n_pass++;
    end
    n_total++; if (first_valid != 2) $display("FAIL restart_stale first_valid got %0d want 2", first_valid); else n_pass++;
    n_total++; if (done_edge != 4) $display("FAIL restart_done_edge got %0d want 4", done_edge); else n_pass++;
  endtask

  task automatic test_async_reset();
    int bad;
    start_gen(0, 100, 1);
    collect(0, 50, 2);
    n_total++; if (bus._valid !== 1'b1) $display("FAIL areset_pre_valid got %b want 1", bus._valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (bus._valid !== 1'b0) $display("FAIL areset_valid got %b want 0", bus._valid); else n_pass++;
    n_total++; if (bus._done !== 1'b1) $display("FAIL areset_done got %b want 1", bus._done); else n_pass++;
    n_total++; if (bus._0 !== 32'sd0 || bus._1 !== 32'sd0) $display("FAIL areset_tuple got (%0d,%0d) want (0,0)", bus._0, bus._1); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    bus._ready = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus._valid !== 1'b0 || bus._done !== 1'b1) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL areset_idle got %0d active cycles want 0", bad); else n_pass++;
  endtask

  task automatic test_random();
    int b, l, s;
    for (int r = 0; r < 20; r++) begin
      b = int'($urandom_range(80)) - 40;
      l = int'($urandom_range(80)) - 40;
      s = int'($urandom_range(8)) - 4;
      build_exp(b, l, s, 1000);
      start_gen(b, l, s);
      collect(2, 600, 0);
      n_total++; if (timed_out) $display("FAIL rand%0d_timeout (%0d,%0d,%0d) got timeout want done", r, b, l, s); else n_pass++;
      n_total++; if (obs.size() != exp_q.size()) $display("FAIL rand%0d_count (%0d,%0d,%0d) got %0d want %0d", r, b, l, s, obs.size(), exp_q.size()); else n_pass++;
      for (int j = 0; j < obs.size() && j < exp_q.size(); j++) begin
        n_total++;
        if (obs[j] !== exp_q[j]) $display("FAIL rand%0d_tuple%0d got (%0d,%0d) want (%0d,%0d)", r, j,
          $signed(obs[j][63:32]), $signed(obs[j][31:0]), $signed(exp_q[j][63:32]), $signed(exp_q[j][31:0]));
        else n_pass++;
      end
      n_total++; if (stall_err != 0 || overlap != 0) $display("FAIL rand%0d_protocol got stall_err %0d overlap %0d want 0/0", r, stall_err, overlap); else n_pass++;
      n_total++;
      if (done_edge != ((exp_q.size() == 0) ? 2 : last_xfer))
        $display("FAIL rand%0d_done_edge got %0d want %0d", r, done_edge, (exp_q.size() == 0) ? 2 : last_xfer);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    bus._start = 1'b0;
    bus.base   = '0;
    bus.limit  = '0;
    bus.step   = '0;
    bus._ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_empty();
    test_overflow();
    test_restart();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hrange_pair.md
# hrange_pair

Hardware range generator: yields `(i, k)` tuples, where `i` walks `range(base, limit, step)` and `k` is the 0-based iteration index. It is the producer instance consumed by generated caller modules such as the duplicating range consumer, through the standard `_start` / `_ready` / `_valid` / `_done` generator handshake. It supports positive and negative steps, one tuple per cycle at full throughput, and well-defined termination on empty ranges and arithmetic overflow.

## Interface
Parameters:
- `WIDTH`, default 32: signed data width of `base`, `limit`, `step`, `_0` and `_1`.

Ports:
- `_clock` in 1: the single clock. All state changes on its rising edge.
- `_reset` in 1: **asynchronous, active-low** reset. Already decided, and fixed.
- `_start` in 1: when high on a clock edge, capture the inputs and begin generating.
- `base` in WIDTH: signed first value of `i`.
- `limit` in WIDTH: signed exclusive bound.
- `step` in WIDTH: signed increment.
- `_ready` in 1: the consumer can accept a tuple this cycle.
- `_valid` out 1: `_0` and `_1` hold a valid tuple.
- `_done` out 1: the generator is exhausted or idle.
- `_0` out WIDTH: signed current `i`.
- `_1` out WIDTH: signed iteration index `k`.

## Operation
- States: `IDLE`, `LOAD`, `EMIT`.
- On reset assertion, asynchronously and while held:
  - `_valid=0`, `_done=1`, `_0=0`, `_1=0`.
  - State is `IDLE`.
- `IDLE`:
  - `_done` is held at 1 and `_valid` at 0.
  - `_start` captures `base`, `limit` and `step` into internal registers, clears `_done` and moves to `LOAD`.
- `LOAD`: evaluate `in_range(base)`.
  - If true: `_0=base`, `_1=0`, `_valid=1`, move to `EMIT`.
  - If false: `_done=1`, move to `IDLE`. This is an empty range.
- `in_range(x)` is defined as:
  - `step>0`: `x<limit`.
  - `step<0`: `x>limit`.
  - `step==0`: false. A zero step is an empty range, never an infinite loop.
  - All comparisons are signed.
- `EMIT`, on an edge with `_valid && _ready` (a transfer):
  - Compute `nxt = _0 + step`.
  - If `in_range(nxt)` and there is no overflow: `_0<=nxt`, `_1<=_1+1`, `_valid` stays 1.
  - Otherwise: `_valid<=0`, `_done<=1`, move to `IDLE`.
- `EMIT` with `_valid && !_ready`: `_0`, `_1` and `_valid` are held unchanged. A stalled tuple never changes.
- `_done` and `_valid` are never high in the same cycle. The consumer discards a tuple that arrives together with `_done`, so `_done` rises only after the final tuple has been accepted.
- `_start` in any state, including mid-`EMIT`, aborts the current sequence:
  - Recapture the inputs.
  - `_valid<=0`, `_done<=0`, move to `LOAD`.
  - `_start` has priority over a simultaneous transfer. The tuple is counted as not consumed by the producer.
- Reset mid-sequence drops the sequence immediately. No tuple is emitted afterwards until a new `_start`.
- `_1` wraps modulo 2^WIDTH. This is unreachable in practice and not checked.

## Timing
- `_start` sampled at edge N:
  - `LOAD` occupies cycle N→N+1.
  - The first tuple is visible after edge N+1, so latency is 2 edges from `_start` to `_valid`.
  - For an empty range, `_done` is high after edge N+1.
- With `_ready` held high, throughput is one tuple per cycle with no bubbles.
- The last transfer at edge M gives `_valid=0` and `_done=1` after edge M. There is no extra cycle.
- Outputs are registered only. There is no combinational path from `_ready` to `_valid`, `_0` or `_1`.

## Configuration
- `HRANGE_PAIR_OVF_GUARD_EN` defined:
  - `nxt` is computed at WIDTH+1 bits, sign-extended.
  - If `nxt` falls outside the signed WIDTH range, the sequence terminates exactly as if `in_range` were false.
- `HRANGE_PAIR_OVF_GUARD_EN` undefined:
  - `nxt` is a plain WIDTH-bit wrapping add.
  - A range whose limit lies beyond the wrap point can wrap and continue. This is the documented behaviour without the guard.

## Structure
- Package `hrange_pair_pkg` holds:
  - The state enum `hrange_pair_state_t` (`IDLE`, `LOAD`, `EMIT`).
  - A `HRANGE_PAIR_WIDTH` default localparam.
- Sub-module `hrange_pair_cmp` is combinational. It takes `x`, `limit`, `step` and the overflow flag, and returns `in_range`. Both `LOAD` and `EMIT` reuse it.

## Test plan
- `(0,10,2)`, `_ready` always high:
  - Tuples `(0,0) (2,1) (4,2) (6,3) (8,4)` on consecutive cycles.
  - `_done` rises at the edge accepting `(8,4)`.
  - `_valid` and `_done` are never high together.
- `(10,0,-3)` with `_ready` toggling 1,0,0,1,…:
  - Tuples `(10,0) (7,1) (4,2) (1,3)`.
  - Each stalled tuple is held stable while `_ready=0`.
- Empty ranges `(5,5,1)`, `(5,0,1)` and `(0,10,0)`:
  - No `_valid`.
  - `_done=1` two edges after `_start`.
- Overflow `(2147483646, 2147483647, 5)` with the guard enabled:
  - Single tuple `(2147483646,0)`, then `_done`.
  - Without the guard, the second tuple is `(-2147483645,1)` and the sequence ends when `in_range` fails.
- `_start (0,100,1)` followed by a second `_start (50,52,1)` after 3 transfers:
  - Output restarts at `(50,0) (51,1)`, then `_done`.
  - No stale tuple appears.
- `_reset` pulsed low asynchronously mid-`EMIT`:
  - `_valid=0` and `_done=1` immediately, without waiting for a clock edge.
  - After release, the block stays idle until `_start`.
